// File: rtl/booth_mul_pkg.sv
// -----------------------------------------------------------------------------
// booth_mul_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   WIDTH_DEF  : default operand width
//   state_e    : controller states (IDLE, RUN)
//   OP_ADD/SUB : Booth recoding of {Q[0], q_m1}
//   cnt_width  : width of the step counter for a given operand width
// -----------------------------------------------------------------------------
package booth_mul_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  // Counter must be able to hold 0..WIDTH.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF + 1);

endpackage

// File: rtl/booth_mul_seq_if.sv
// -----------------------------------------------------------------------------
// booth_mul_seq_if
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
//   start        : request from the control unit
//   multiplicand : signed operand M
//   multiplier   : signed operand Q
//   busy         : operation in progress
//   done         : one-cycle completion pulse
//   hi / lo      : upper / lower half of the 2*WIDTH-bit product
// Modports: master (control unit side), slave (multiplier side).
// -----------------------------------------------------------------------------
interface booth_mul_seq_if
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic                    start;
  logic signed [WIDTH-1:0] multiplicand;
  logic signed [WIDTH-1:0] multiplier;
  logic                    busy;
  logic                    done;
  logic        [WIDTH-1:0] hi;
  logic        [WIDTH-1:0] lo;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/booth_mul_step.sv
// -----------------------------------------------------------------------------
// booth_mul_step
// One combinational radix-2 Booth step: conditional add/subtract of the
// sign-extended multiplicand into A, then arithmetic right shift of
// {A, Q, q_m1} by one bit.
//   a_i / a_o     : partial-product accumulator (WIDTH+1 bits, signed)
//   q_i / q_o     : multiplier register (shifts in low product bits)
//   qm1_i / qm1_o : Booth history bit
//   m_i           : multiplicand
// -----------------------------------------------------------------------------
module booth_mul_step
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH:0]   a_i,
  input  logic        [WIDTH-1:0] q_i,
  input  logic                    qm1_i,
  input  logic signed [WIDTH-1:0] m_i,
  output logic signed [WIDTH:0]   a_o,
  output logic        [WIDTH-1:0] q_o,
  output logic                    qm1_o
);

  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] sum;

  // The extra accumulator bit keeps -(-2^(WIDTH-1)) representable.
  assign m_ext = {m_i[WIDTH-1], m_i};

  always_comb begin
    sum = a_i;
    case ({q_i[0], qm1_i})
      OP_ADD:  sum = a_i + m_ext;
      OP_SUB:  sum = a_i - m_ext;
      default: sum = a_i;
    endcase
  end

  assign a_o   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];

endmodule

// File: rtl/booth_mul_seq.sv
// -----------------------------------------------------------------------------
// booth_mul_seq
// Sequential signed radix-2 Booth multiplier, one Booth step per clock.
// Full 2*WIDTH-bit product is written to the hi/lo pair on completion.
//   clk : system clock, rising edge
//   clr : synchronous active-high reset, priority over everything
//   bus : booth_mul_seq_if.slave (start, multiplicand, multiplier,
//         busy, done, hi, lo)
// Optional build macro BOOTH_MUL_EARLY_DONE_EN: a zero operand on the accept
// edge completes immediately (hi=lo=0, done next cycle, busy never set).
// -----------------------------------------------------------------------------
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  booth_mul_seq_if.slave   bus
);

  localparam int unsigned    CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e                  state_q, state_d;
  logic signed [WIDTH:0]   a_q, a_d;
  logic        [WIDTH-1:0] q_q, q_d;
  logic                    qm1_q, qm1_d;
  logic signed [WIDTH-1:0] m_q, m_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic        [WIDTH-1:0] hi_q, hi_d;
  logic        [WIDTH-1:0] lo_q, lo_d;
  logic                    done_q, done_d;

  logic signed [WIDTH:0]   a_nx;
  logic        [WIDTH-1:0] q_nx;
  logic                    qm1_nx;
  logic                    zero_skip;

  booth_mul_step #(.WIDTH(WIDTH)) u_step (
    .a_i   (a_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .a_o   (a_nx),
    .q_o   (q_nx),
    .qm1_o (qm1_nx)
  );

`ifdef BOOTH_MUL_EARLY_DONE_EN
  assign zero_skip = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (zero_skip) begin
            hi_d   = '0;
            lo_d   = '0;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            m_d     = bus.multiplicand;
            q_d     = bus.multiplier;
            a_d     = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        a_d   = a_nx;
        q_d   = q_nx;
        qm1_d = qm1_nx;
        cnt_d = cnt_q + 1'b1;
        // Final step: publish the post-shift product in the same edge.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          hi_d    = a_nx[WIDTH-1:0];
          lo_d    = q_nx;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
